fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. It sits directly upstream of the instruction decoder and feeds `if_id_instr` to the OpCode/Funct decode. It owns the PC, load-use hazard stalls, and redirects:
- jump / jump-register resolved in ID, from the decoder's Jump code;
- taken branches resolved in EX.

It also keeps stall and flush event counters for performance debug.

---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS
// pipeline. It owns the PC, detects load-use hazards, applies jump and branch
// redirects, and counts stall and flush events.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_data,
  input  logic [1:0]  id_jump,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_ex_memrd,
  input  logic [4:0]  id_ex_rt,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        stall,
  output logic        flush_id,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic [REGW-1:0] idRs;
  logic [REGW-1:0] idRt;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] jumpTarget;
  logic            jumpTaken;

  // Load-use hazard: rt is compared even for instructions that do not read it.
  always_comb begin
    idRs  = if_id_instr[25:21];
    idRt  = if_id_instr[20:16];
    stall = id_ex_memrd & if_id_valid & (id_ex_rt != REGW'(0)) &
            ((id_ex_rt == idRs) | (id_ex_rt == idRt));
    flush_id = ex_branch_taken;
  end

  // Sequential PC and jump target selection; code 10 is j/jal, any other
  // non-zero code uses the forwarded register value.
  always_comb begin
    pcPlus4    = pc + XLEN'(4);
    jumpTaken  = (id_jump != 2'b00) & if_id_valid;
    jumpTarget = id_jr_target;
    if (id_jump == 2'b10) begin
      jumpTarget = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    end
  end

  // PC, IF/ID and counter update: reset > branch > stall > jump > sequential.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (ex_branch_taken) begin
      pc          <= ex_branch_target;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      flush_cnt   <= flush_cnt + XLEN'(1);
    end else if (stall) begin
      stall_cnt   <= stall_cnt + XLEN'(1);
    end else if (jumpTaken) begin
      pc          <= jumpTarget;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      flush_cnt   <= flush_cnt + XLEN'(1);
    end else begin
      pc          <= pcPlus4;
      if_id_instr <= imem_data;
      if_id_pc4   <= pcPlus4;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, free-run, load-use stall, jumps,
// branch priority, PC wrap and reset during a stall.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_data;
  logic [1:0]  id_jump;
  logic [31:0] id_jr_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        id_ex_memrd;
  logic [4:0]  id_ex_rt;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        stall;
  logic        flush_id;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int vectors;
  int miscompares;

  localparam logic [31:0] ADDI  = 32'h2008_0005;
  localparam logic [31:0] ADD   = 32'h0109_5020;
  localparam logic [31:0] JINS  = 32'h0810_0004;
  localparam logic [31:0] JRINS = 32'h0100_0008;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .imem_data        (imem_data),
    .id_jump          (id_jump),
    .id_jr_target     (id_jr_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_ex_memrd      (id_ex_memrd),
    .id_ex_rt         (id_ex_rt),
    .pc               (pc),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .if_id_valid      (if_id_valid),
    .stall            (stall),
    .flush_id         (flush_id),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (pc !== 32'h0040_0000) begin
      miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0040_0000);
    end
    vectors++;
    if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      miscompares++; $display("FAIL reset_ifid: got %h %h %b expected zeros", if_id_instr, if_id_pc4, if_id_valid);
    end
    vectors++;
    if ({stall_cnt, flush_cnt} !== 64'h0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d %0d expected 0 0", stall_cnt, flush_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    step();
    vectors++;
    if (pc !== 32'h0040_0004) begin
      miscompares++; $display("FAIL run_pc1: got %h expected %h", pc, 32'h0040_0004);
    end
    vectors++;
    if (if_id_pc4 !== 32'h0040_0004 || if_id_valid !== 1'b1 || if_id_instr !== ADDI) begin
      miscompares++; $display("FAIL run_ifid: got %h %h %b expected %h %h 1", if_id_instr, if_id_pc4, if_id_valid, ADDI, 32'h0040_0004);
    end
    step();
    vectors++;
    if (pc !== 32'h0040_0008) begin
      miscompares++; $display("FAIL run_pc2: got %h expected %h", pc, 32'h0040_0008);
    end
    vectors++;
    if (stall !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      miscompares++; $display("FAIL run_cnt: got stall=%b %0d %0d expected 0 0 0", stall, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    imem_data = ADD;
    step();
    imem_data = ADDI;
    // pc is now 0x0040000C with add in IF/ID
    id_ex_memrd = 1'b1;
    id_ex_rt    = 5'd8;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_stall: got %b expected 1", stall);
    end
    step();
    vectors++;
    if (pc !== 32'h0040_000C || if_id_instr !== ADD || if_id_pc4 !== 32'h0040_000C) begin
      miscompares++; $display("FAIL lu_hold: got %h %h %h expected %h %h %h", pc, if_id_instr, if_id_pc4, 32'h0040_000C, ADD, 32'h0040_000C);
    end
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
    end
    id_ex_rt = 5'd0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_rt0: got %b expected 0", stall);
    end
    id_ex_rt = 5'd9;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_rtmatch: got %b expected 1", stall);
    end
    id_ex_memrd = 1'b0;
    id_ex_rt    = 5'd0;
    step();
    vectors++;
    if (pc !== 32'h0040_0010 || if_id_instr !== ADDI || stall_cnt !== 32'd1) begin
      miscompares++; $display("FAIL lu_resume: got %h %h %0d expected %h %h 1", pc, if_id_instr, stall_cnt, 32'h0040_0010, ADDI);
    end
  endtask

  task automatic test_jump();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    imem_data = JINS;
    step();
    imem_data = ADDI;
    id_jump   = 2'b10;
    vectors++;
    if (if_id_pc4 !== 32'h0040_0008 || if_id_instr !== JINS) begin
      miscompares++; $display("FAIL j_setup: got %h %h expected %h %h", if_id_pc4, if_id_instr, 32'h0040_0008, JINS);
    end
    step();
    id_jump = 2'b00;
    vectors++;
    if (pc !== 32'h0040_0010) begin
      miscompares++; $display("FAIL j_pc: got %h expected %h", pc, 32'h0040_0010);
    end
    vectors++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || flush_cnt !== 32'd1) begin
      miscompares++; $display("FAIL j_flush: got %b %h %0d expected 0 0 1", if_id_valid, if_id_instr, flush_cnt);
    end
  endtask

  task automatic test_jr_stall();
    imem_data = JRINS;
    step();
    imem_data    = ADDI;
    id_jump      = 2'b01;
    id_jr_target = 32'h0040_0100;
    id_ex_memrd  = 1'b1;
    id_ex_rt     = 5'd8;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL jr_stall: got %b expected 1", stall);
    end
    step();
    vectors++;
    if (pc !== 32'h0040_0014 || if_id_instr !== JRINS || stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
      miscompares++; $display("FAIL jr_hold: got %h %h %0d %0d expected %h %h 1 1", pc, if_id_instr, stall_cnt, flush_cnt, 32'h0040_0014, JRINS);
    end
    id_ex_memrd = 1'b0;
    step();
    id_jump = 2'b00;
    vectors++;
    if (pc !== 32'h0040_0100 || if_id_valid !== 1'b0 || flush_cnt !== 32'd2) begin
      miscompares++; $display("FAIL jr_redirect: got %h %b %0d expected %h 0 2", pc, if_id_valid, flush_cnt, 32'h0040_0100);
    end
  endtask

  task automatic test_branch_priority();
    imem_data = ADD;
    step();
    imem_data        = ADDI;
    id_ex_memrd      = 1'b1;
    id_ex_rt         = 5'd8;
    id_jump          = 2'b10;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0040_0040;
    #1;
    vectors++;
    if (stall !== 1'b1 || flush_id !== 1'b1) begin
      miscompares++; $display("FAIL br_comb: got stall=%b flush_id=%b expected 1 1", stall, flush_id);
    end
    step();
    id_ex_memrd     = 1'b0;
    id_ex_rt        = 5'd0;
    id_jump         = 2'b00;
    ex_branch_taken = 1'b0;
    vectors++;
    if (pc !== 32'h0040_0040 || {if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      miscompares++; $display("FAIL br_redirect: got %h %h %h %b expected %h flushed", pc, if_id_instr, if_id_pc4, if_id_valid, 32'h0040_0040);
    end
    vectors++;
    if (flush_cnt !== 32'd3 || stall_cnt !== 32'd1) begin
      miscompares++; $display("FAIL br_cnt: got flush=%0d stall=%0d expected 3 1", flush_cnt, stall_cnt);
    end
    #1;
    vectors++;
    if (flush_id !== 1'b0) begin
      miscompares++; $display("FAIL br_flushid_low: got %b expected 0", flush_id);
    end
  endtask

  task automatic test_wrap_reset();
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'hFFFF_FFFC;
    step();
    ex_branch_taken = 1'b0;
    imem_data       = ADD;
    vectors++;
    if (pc !== 32'hFFFF_FFFC || flush_cnt !== 32'd4) begin
      miscompares++; $display("FAIL wrap_setup: got %h %0d expected %h 4", pc, flush_cnt, 32'hFFFF_FFFC);
    end
    step();
    imem_data = ADDI;
    vectors++;
    if (pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== ADD) begin
      miscompares++; $display("FAIL wrap_pc: got %h %h %b %h expected 0 0 1 %h", pc, if_id_pc4, if_id_valid, if_id_instr, ADD);
    end
    id_ex_memrd = 1'b1;
    id_ex_rt    = 5'd9;
    reset       = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_stall_pre: got %b expected 1", stall);
    end
    step();
    reset       = 1'b0;
    id_ex_memrd = 1'b0;
    id_ex_rt    = 5'd0;
    vectors++;
    if (pc !== 32'h0040_0000 || {if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      miscompares++; $display("FAIL rst_mid_state: got %h %h %h %b expected %h zeros", pc, if_id_instr, if_id_pc4, if_id_valid, 32'h0040_0000);
    end
    vectors++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rst_mid_cnt: got %0d %0d expected 0 0", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    imem_data        = ADDI;
    id_jump          = 2'b00;
    id_jr_target     = 32'h0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
    id_ex_memrd      = 1'b0;
    id_ex_rt         = 5'd0;
    test_reset();
    test_free_run();
    test_load_use();
    test_jump();
    test_jr_stall();
    test_branch_priority();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
